nn_calc_engine: RTL and testbench

NN_CALC_ENGINE -- requirements
Module: nn_calc_engine

---
 rtl/nn_pkg.sv | 37 +++
 rtl/nn_mac.sv | 50 +++++
 rtl/nn_calc_engine.sv | 139 +++++++++++++
 tb/tb_nn_calc_engine.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nn_pkg
// Brief   : Shared types, sizes and the result saturation helper for nn_calc_engine.
// Revision: 1.0
// ============================================================================
package nn_pkg;

  localparam int N_IN_DEF  = 784;
  localparam int N_OUT_DEF = 10;
  localparam int ACC_W     = 27;
  localparam int RES_W     = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic signed [ACC_W-1:0] C_ACC_MAX = 65535;
  localparam logic signed [ACC_W-1:0] C_ACC_MIN = -65536;

  function automatic logic signed [RES_W-1:0] sat_res(input logic signed [ACC_W-1:0] acc);
    logic signed [RES_W-1:0] w_res;
    if (acc > C_ACC_MAX)
      w_res = 17'h0FFFF;
    else if (acc < C_ACC_MIN)
      w_res = 17'h10000;
    else
      w_res = acc[RES_W-1:0];
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_mac.sv
`default_nettype none
// ============================================================================
// Module  : nn_mac
// Brief   : Unsigned-pixel x signed-weight multiplier with a product register
//           feeding a clearable signed accumulator.
// Revision: 1.0
// ============================================================================
module nn_mac
  import nn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic [7:0]              i_pixel,
  input  logic [7:0]              i_weight,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [RES_W-1:0] w_pix;
  logic signed [RES_W-1:0] w_wt;
  logic signed [RES_W-1:0] w_prod;
  logic signed [RES_W-1:0] r_prod;
  logic                    r_pv;
  logic signed [ACC_W-1:0] r_acc;

  // Zero-extend the pixel and sign-extend the weight so the full product fits 17 bits.
  assign w_pix  = {{(RES_W-8){1'b0}}, i_pixel};
  assign w_wt   = {{(RES_W-8){i_weight[7]}}, i_weight};
  assign w_prod = w_pix * w_wt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
      r_pv   <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_prod <= w_prod;
      r_pv   <= i_valid;
      if (i_clear)
        r_acc <= '0;
      else if (r_pv)
        r_acc <= r_acc + ACC_W'(r_prod);
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/nn_calc_engine.sv
`default_nettype none
// ============================================================================
// Module  : nn_calc_engine
// Brief   : Sequential dot-product engine, N_OUT neurons over N_IN pixels,
//           saturated 17-bit results. Optional ReLU via NN_CALC_RELU_EN.
// Revision: 1.0
// ============================================================================
module nn_calc_engine
  import nn_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_calc,
  output logic [9:0]       pixel_rd_addr,
  input  logic [15:0]      pixel_rd_data,
  output logic [13:0]      weight_rd_addr,
  input  logic [15:0]      weight_rd_data,
  input  logic [3:0]       output_address,
  output logic [RES_W-1:0] result_output,
  output logic             done_calc,
  output logic             busy
);

  localparam logic [9:0]  C_I_LAST = 10'(N_IN - 1);
  localparam logic [3:0]  C_J_LAST = 4'(N_OUT - 1);
  localparam logic [13:0] C_W_STEP = 14'(N_IN);

  state_t                  r_state;
  logic [9:0]              r_i;
  logic [3:0]              r_j;
  logic [13:0]             r_wbase;
  logic                    r_drain;
  logic                    r_start_q;
  logic                    r_armed;
  logic                    r_done;
  logic                    r_rd_vld;
  logic [RES_W-1:0]        r_res [16];

  logic                    w_start;
  logic                    w_mac_clr;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [RES_W-1:0] w_sat;
  logic signed [RES_W-1:0] w_store;
  logic                    w_unused;

  // r_armed blocks a start level that was already high when reset released.
  assign w_start   = (r_state == S_IDLE) && r_armed && !r_start_q && start_calc;
  assign w_mac_clr = w_start || (r_state == S_STORE);
  assign w_sat     = sat_res(w_acc);
  assign w_unused  = ^{pixel_rd_data[15:8], weight_rd_data[15:8]};

`ifdef NN_CALC_RELU_EN
  assign w_store = w_sat[RES_W-1] ? '0 : w_sat;
`else
  assign w_store = w_sat;
`endif

  nn_mac u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_mac_clr),
    .i_valid  (r_rd_vld),
    .i_pixel  (pixel_rd_data[7:0]),
    .i_weight (weight_rd_data[7:0]),
    .o_acc    (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_wbase   <= '0;
      r_drain   <= 1'b0;
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
      r_done    <= 1'b0;
      r_rd_vld  <= 1'b0;
      for (int k = 0; k < 16; k++) r_res[k] <= '0;
    end else begin
      r_start_q <= start_calc;
      r_armed   <= r_armed | ~start_calc;
      r_rd_vld  <= (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_i     <= '0;
            r_j     <= '0;
            r_wbase <= '0;
          end
        end
        S_RUN: begin
          if (r_i == C_I_LAST) begin
            r_i     <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_i <= r_i + 10'd1;
          end
        end
        S_DRAIN: begin
          r_drain <= ~r_drain;
          if (r_drain) r_state <= S_STORE;
        end
        S_STORE: begin
          r_res[r_j] <= w_store;
          if (r_j == C_J_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_j     <= r_j + 4'd1;
            r_wbase <= r_wbase + C_W_STEP;
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          // First DONE cycle raises done; it then holds until the request drops.
          if (!r_done) begin
            r_done <= 1'b1;
          end else if (!start_calc) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixel_rd_addr  = (r_state == S_RUN) ? r_i : '0;
  assign weight_rd_addr = (r_state == S_RUN) ? (r_wbase + 14'(r_i)) : '0;
  assign result_output  = (int'(output_address) < N_OUT) ? r_res[output_address] : '0;
  assign done_calc      = r_done;
  assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_STORE);

endmodule
`default_nettype wire

// File: tb/tb_nn_calc_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_nn_calc_engine
// Brief   : Directed self-checking bench: a 4x2 instance and a default 784x10 instance.
// Revision: 1.0
// ============================================================================
module tb_nn_calc_engine;

  localparam int BIG_LAT   = 10 * (784 + 3) + 1;
  localparam int SMALL_LAT = 2 * (4 + 3) + 1;
`ifdef NN_CALC_RELU_EN
  localparam int EXP_S1_J1 = 0;
  localparam int EXP_S2_J1 = 0;
  localparam int EXP_B_NEG = 0;
`else
  localparam int EXP_S1_J1 = -10;
  localparam int EXP_S2_J1 = -49920;
  localparam int EXP_B_NEG = -65536;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start_s, done_s, busy_s;
  logic [9:0]  paddr_s;
  logic [13:0] waddr_s;
  logic [15:0] pdata_s = '0, wdata_s = '0;
  logic [3:0]  oaddr_s;
  logic [16:0] res_s;

  logic        start_b, done_b, busy_b;
  logic [9:0]  paddr_b;
  logic [13:0] waddr_b;
  logic [15:0] pdata_b = '0, wdata_b = '0;
  logic [3:0]  oaddr_b;
  logic [16:0] res_b;

  logic [7:0] pix_s [0:3];
  logic [7:0] wt_s  [0:7];
  logic [7:0] pix_b [0:1023];
  logic [7:0] wt_b  [0:16383];

  int n_tests = 0;
  int n_fail  = 0;
  int e;

  nn_calc_engine #(.N_IN(4), .N_OUT(2)) u_small (
    .clk(clk), .rst(rst), .start_calc(start_s),
    .pixel_rd_addr(paddr_s), .pixel_rd_data(pdata_s),
    .weight_rd_addr(waddr_s), .weight_rd_data(wdata_s),
    .output_address(oaddr_s), .result_output(res_s),
    .done_calc(done_s), .busy(busy_s)
  );

  nn_calc_engine u_big (
    .clk(clk), .rst(rst), .start_calc(start_b),
    .pixel_rd_addr(paddr_b), .pixel_rd_data(pdata_b),
    .weight_rd_addr(waddr_b), .weight_rd_data(wdata_b),
    .output_address(oaddr_b), .result_output(res_b),
    .done_calc(done_b), .busy(busy_b)
  );

  // One-cycle-latency memories; upper bytes carry junk the engine must ignore.
  always @(posedge clk) begin
    pdata_s <= {8'hA5, pix_s[paddr_s[1:0]]};
    wdata_s <= {8'h5A, wt_s[waddr_s[2:0]]};
    pdata_b <= {8'hC3, pix_b[paddr_b]};
    wdata_b <= {8'h3C, wt_b[waddr_b]};
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_wait(input bit big, output int edges);
    edges = -1;
    for (int n = 1; n <= BIG_LAT + 20; n++) begin
      @(posedge clk); #1;
      if ((big ? done_b : done_s) === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic fill_big(input logic [7:0] pv, input logic [7:0] wv);
    for (int k = 0; k < 1024; k++) pix_b[k] = pv;
    for (int k = 0; k < 16384; k++) wt_b[k] = wv;
  endtask

  task automatic chk_big_results(input string tag, input int exp);
    for (int a = 0; a < 10; a++) begin
      oaddr_b = 4'(a);
      @(negedge clk);
      chk($sformatf("%s_res%0d", tag, a), 32'($signed(res_b)), exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_s = 1'b0; start_b = 1'b0; oaddr_s = '0; oaddr_b = '0;
    fill_big(8'd255, 8'd127);
    for (int k = 0; k < 8; k++) wt_s[k] = 8'd0;
    for (int k = 0; k < 4; k++) pix_s[k] = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_res", 32'($signed(res_s)), 0);
    chk("rst_paddr", paddr_b, 0);
    chk("rst_waddr", waddr_b, 0);

    // Small case 1: pixels 1..4, weights +1 then -1
    pix_s[0] = 8'd1; pix_s[1] = 8'd2; pix_s[2] = 8'd3; pix_s[3] = 8'd4;
    for (int k = 0; k < 4; k++) wt_s[k] = 8'h01;
    for (int k = 4; k < 8; k++) wt_s[k] = 8'hFF;
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    chk("s1_busy", busy_s, 1);
    run_wait(1'b0, e);
    chk("s1_latency", e, SMALL_LAT);
    chk("s1_busy_done", busy_s, 0);
    oaddr_s = 4'd0; @(negedge clk); chk("s1_res0", 32'($signed(res_s)), 10);
    oaddr_s = 4'd1; @(negedge clk); chk("s1_res1", 32'($signed(res_s)), EXP_S1_J1);
    oaddr_s = 4'd2; @(negedge clk); chk("s1_res2_oob", 32'($signed(res_s)), 0);
    chk("s1_done_drop", done_s, 0);

    // Small case 2: unsigned pixels, mixed signed weights
    pix_s[0] = 8'd255; pix_s[1] = 8'd128; pix_s[2] = 8'd0; pix_s[3] = 8'd7;
    wt_s[0] = 8'h02; wt_s[1] = 8'hFD; wt_s[2] = 8'h64; wt_s[3] = 8'h01;
    for (int k = 4; k < 8; k++) wt_s[k] = 8'h80;
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    run_wait(1'b0, e);
    chk("s2_latency", e, SMALL_LAT);
    oaddr_s = 4'd0; @(negedge clk); chk("s2_res0", 32'($signed(res_s)), 133);
    oaddr_s = 4'd1; @(negedge clk); chk("s2_res1", 32'($signed(res_s)), EXP_S2_J1);

    // Big: positive saturation, level start held through DONE
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1;
    chk("b1_busy", busy_b, 1);
    run_wait(1'b1, e);
    chk("b1_latency", e, BIG_LAT);
    repeat (5) @(posedge clk);
    #1 chk("b1_done_hold", done_b, 1);
    start_b = 1'b0;
    @(posedge clk); #1 chk("b1_done_clear", done_b, 0);
    chk_big_results("b1", 65535);
    oaddr_b = 4'd10; @(negedge clk); chk("b1_addr10", 32'($signed(res_b)), 0);
    oaddr_b = 4'd15; @(negedge clk); chk("b1_addr15", 32'($signed(res_b)), 0);
    repeat (20) @(posedge clk);
    chk_big_results("b1_stable", 65535);

    // Big: negative saturation with a start re-edge during RUN
    fill_big(8'd255, 8'h80);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1 start_b = 1'b0;
    @(posedge clk); #1 start_b = 1'b1;
    chk("b2_busy_mid", busy_b, 1);
    run_wait(1'b1, e);
    chk("b2_latency", (e < 0) ? -1 : e + 101, BIG_LAT);
    repeat (3) @(posedge clk);
    #1 chk("b2_done_hold", done_b, 1);
    start_b = 1'b0;
    @(posedge clk); #1 chk("b2_done_clear", done_b, 0);
    chk_big_results("b2", EXP_B_NEG);

    // Big: reset mid-run, then start held high through reset must not fire
    fill_big(8'd255, 8'd127);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("b3_rst_busy", busy_b, 0);
    chk("b3_rst_done", done_b, 0);
    chk("b3_rst_paddr", paddr_b, 0);
    for (int a = 0; a < 16; a++) begin
      oaddr_b = 4'(a);
      #1 chk($sformatf("b3_rst_res%0d", a), 32'($signed(res_b)), 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("b3_no_level_start", busy_b, 0);
    start_b = 1'b0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 chk("b3_busy", busy_b, 1);
    run_wait(1'b1, e);
    chk("b3_latency", e, BIG_LAT);
    start_b = 1'b0;
    oaddr_b = 4'd0; @(negedge clk); chk("b3_res0", 32'($signed(res_b)), 65535);
    oaddr_b = 4'd9; @(negedge clk); chk("b3_res9", 32'($signed(res_b)), 65535);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
